// File: rtl/adder_seg_scan.sv
// adder_seg_scan: debounced, button-sampled adder whose WIDTH+1-bit result is shown on a scanned hex 7-segment display.
// Optional accumulate mode on MODE=1 is built only when ADDER_ACCUM_EN is defined.
module adder_seg_scan #(
   parameter int WIDTH = 8,
   parameter int DEB_CYCLES = 270000,
   parameter int SCAN_DIV = 27000,
   localparam int DIGITS = (WIDTH + 4) / 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WIDTH-1:0]  IN_A,
   input  logic [WIDTH-1:0]  IN_B,
   input  logic              BTN_N,
   input  logic              MODE,
   output logic [6:0]        OUT,
   output logic [DIGITS-1:0] DIG_SEL,
   output logic              CARRY
);
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;
   state_t state_q, state_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic press_q, press_d;
   logic [WIDTH-1:0] a1_q, a1_d, a2_q, a2_d, b1_q, b1_d, b2_q, b2_d;
   logic btn1_q, btn1_d, btn2_q, btn2_d;
   logic [WIDTH:0] result_q, result_d, sum;
   logic [SW-1:0] scan_q, scan_d;
   logic [DIGITS-1:0] dig_q, dig_d;
   logic [6:0] out_q, out_d;
   logic [4*DIGITS-1:0] padded;
   logic [3:0] nib;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h3F;
         4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;
         4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;
         4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;
         4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;
         4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;
         4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;
         4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;
         default: seg7 = 7'h71;
      endcase
   endfunction

`ifdef ADDER_ACCUM_EN
   always_comb sum = MODE ? {1'b0, result_q[WIDTH-1:0]} + {1'b0, ~a2_q} : {1'b0, ~a2_q} + {1'b0, ~b2_q};
`else
   logic unused_mode;
   assign unused_mode = MODE;
   always_comb sum = {1'b0, ~a2_q} + {1'b0, ~b2_q};
`endif

   always_comb begin
      a1_d = IN_A;
      a2_d = a1_q;
      b1_d = IN_B;
      b2_d = b1_q;
      btn1_d = BTN_N;
      btn2_d = btn1_q;
      state_d = state_q;
      deb_cnt_d = deb_cnt_q;
      press_d = 1'b0;
      case (state_q)
         IDLE: if (!btn2_q) begin
            state_d = PRESS_WAIT;
            deb_cnt_d = '0;
         end
         PRESS_WAIT: if (btn2_q) begin
            state_d = IDLE;
            deb_cnt_d = '0;
         end else if (deb_cnt_q == DEB_MAX) begin
            state_d = HELD;
            press_d = 1'b1;
            deb_cnt_d = '0;
         end else deb_cnt_d = deb_cnt_q + 1'b1;
         HELD: if (btn2_q) begin
            state_d = REL_WAIT;
            deb_cnt_d = '0;
         end
         REL_WAIT: if (!btn2_q) begin
            state_d = HELD;
            deb_cnt_d = '0;
         end else if (deb_cnt_q == DEB_MAX) begin
            state_d = IDLE;
            deb_cnt_d = '0;
         end else deb_cnt_d = deb_cnt_q + 1'b1;
         default: state_d = IDLE;
      endcase
      result_d = press_q ? sum : result_q;
      scan_d = (scan_q == SCAN_MAX) ? '0 : scan_q + 1'b1;
      dig_d = (scan_q == SCAN_MAX) ? ((dig_q << 1) | (dig_q >> (DIGITS - 1))) : dig_q;
      // Decode from the next digit select so OUT and DIG_SEL switch on the same edge
      padded = (4*DIGITS)'(result_q);
      nib = '0;
      for (int i = 0; i < DIGITS; i++) if (dig_d[i]) nib = nib | padded[i*4 +: 4];
      out_d = seg7(nib);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         a1_q <= '0;
         a2_q <= '0;
         b1_q <= '0;
         b2_q <= '0;
         btn1_q <= 1'b1;
         btn2_q <= 1'b1;
         state_q <= IDLE;
         deb_cnt_q <= '0;
         press_q <= 1'b0;
         result_q <= '0;
         scan_q <= '0;
         dig_q <= DIGITS'(1);
         out_q <= 7'h3F;
      end else begin
         a1_q <= a1_d;
         a2_q <= a2_d;
         b1_q <= b1_d;
         b2_q <= b2_d;
         btn1_q <= btn1_d;
         btn2_q <= btn2_d;
         state_q <= state_d;
         deb_cnt_q <= deb_cnt_d;
         press_q <= press_d;
         result_q <= result_d;
         scan_q <= scan_d;
         dig_q <= dig_d;
         out_q <= out_d;
      end
   end

   assign OUT = out_q;
   assign DIG_SEL = dig_q;
   assign CARRY = result_q[WIDTH];
endmodule
